// File: rtl/grev_pkg.sv
// Shared types and elaboration helpers for the iterative GREV unit.
package grev_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of butterfly stages for a power-of-two width.
  function automatic int grev_log2(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit grev_is_pow2(input int w);
    return (w >= 2) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/grev_stage.sv
// One combinational GREV butterfly: swaps adjacent 2^idx-bit blocks when enabled.
// Zero latency, no flow control.
module grev_stage
  import grev_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IW    = 3
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [IW-1:0]    i_idx,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data
);

  localparam int L = grev_log2(WIDTH);

  logic [L-1:0][WIDTH-1:0] w_swap;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      assign w_swap[k][j] = i_data[j ^ (1 << k)];
    end
  end

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      for (int k = 0; k < L; k++) begin
        if (i_idx == IW'(k)) o_data = w_swap[k];
      end
    end
  end

endmodule

// File: rtl/grev_unit.sv
// Iterative GREV: dout[j] = din[j ^ ctl], L/SPC cycles from accept to out_valid.
// Holds the result in DONE until out_ready; in_ready follows out_ready in DONE.
module grev_unit
  import grev_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int SPC   = 1,
  localparam int L     = grev_log2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [L-1:0]     ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  localparam int CW = $clog2(L + 1);

  if (!grev_is_pow2(WIDTH)) begin : g_bad_width
    $error("grev_unit: WIDTH must be a power of two, at least 2");
  end
  if ((SPC < 1) || ((L % ((SPC < 1) ? 1 : SPC)) != 0)) begin : g_bad_spc
    $error("grev_unit: SPC must be positive and divide log2(WIDTH)");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_data;
  logic [L-1:0]      r_ctl;
  logic [CW-1:0]     r_cnt;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic              w_in_rdy;
  logic              w_out_vld;

  logic [SPC:0][WIDTH-1:0] w_chain;

  assign w_chain[0] = r_data;

  for (genvar s = 0; s < SPC; s++) begin : g_stage
    logic [CW-1:0] w_idx;
    logic [L-1:0]  w_ctl_sh;
    assign w_idx    = r_cnt + CW'(s);
    assign w_ctl_sh = r_ctl >> w_idx;

    grev_stage #(
      .WIDTH (WIDTH),
      .IW    (CW)
    ) u_stage (
      .i_data (w_chain[s]),
      .i_idx  (w_idx),
      .i_en   (w_ctl_sh[0]),
      .o_data (w_chain[s+1])
    );
  end

  assign w_last = ((r_cnt + CW'(SPC)) == CW'(L));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_rdy    = 1'b0;
    w_out_vld   = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_rdy = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_vld = 1'b1;
        // Result leaving this edge frees the unit for a same-edge accept.
        if (out_ready) begin
          w_in_rdy = 1'b1;
          if (in_valid) begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_ctl  <= '0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_data <= din;
      r_ctl  <= ctl;
      r_cnt  <= '0;
    end else if (w_step) begin
      r_data <= w_chain[SPC];
      r_cnt  <= r_cnt + CW'(SPC);
    end
  end

  assign in_ready  = w_in_rdy;
  assign out_valid = w_out_vld;
  assign dout      = r_data;
  assign busy      = (r_state != IDLE);

endmodule
